// File: rtl/pe_row_output_drain.sv
// Purpose : drain controller for one PE row; captures every PE psum into its output
//           register, then shifts the words out of the tail PE as a valid/ready stream.
// Latency : start -> first out_valid in 2 cycles; full drain N_PE+3 cycles with ready held.
// Backpressure: out_ready low holds out_data/out_idx and stops the PE chain shifting.
//
// Ports:
//   clk, rst (sync, active-low)   | start, busy, done  - run control
//   pe_en_out, pe_eject_ctrl,     | drive all PEs of the row in parallel
//   pe_clear_psum                 |
//   data_in                       | output_out of the last PE (index N_PE-1)
//   out_data, out_idx, out_valid, | drained word stream; out_last marks PE index 0
//   out_ready, out_last           |
module pe_row_output_drain #(
  parameter int DW         = 20,
  parameter int N_PE       = 8,
  parameter int RELU       = 0,
  parameter int CLEAR_PSUM = 1,
  localparam int IW        = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pe_en_out,
  output logic          pe_eject_ctrl,
  output logic          pe_clear_psum,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [IW-1:0] LAST_CNT = IW'(N_PE - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] word;

  // ReLU is a pure select on the sign bit; no width change.
  assign word = ((RELU != 0) && data_in[DW-1]) ? '0 : data_in;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    busy          = 1'b0;
    done          = 1'b0;
    pe_en_out     = 1'b0;
    pe_eject_ctrl = 1'b0;
    pe_clear_psum = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_idx       = '0;
    out_last      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        // Every PE loads its own psum; a psum clear on the same edge is safe
        // because the output register samples the pre-clear value.
        busy          = 1'b1;
        pe_en_out     = 1'b1;
        pe_clear_psum = (CLEAR_PSUM != 0);
        cnt_d         = '0;
        state_d       = S_DRAIN;
      end

      S_DRAIN: begin
        busy          = 1'b1;
        out_valid     = 1'b1;
        pe_eject_ctrl = 1'b1;
        out_data      = word;
        out_idx       = LAST_CNT - cnt_q;
        out_last      = (cnt_q == LAST_CNT);
        // The shift enable is combinational from out_ready so the next word
        // is at the tail on the cycle right after the handshake.
        if (out_ready) begin
          if (cnt_q != LAST_CNT) begin
            pe_en_out = 1'b1;
            cnt_d     = cnt_q + IW'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_row_output_drain.sv
// Bench for pe_row_output_drain: two instances (RELU=0 and RELU=1) share stimulus,
// each drives its own behavioural PE-row model; drained words are compared with
// psums loaded by the bench, in tail-first order.
module tb_pe_row_output_drain;
  localparam int DW = 20;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam logic [DW-1:0] ACC_ONE = 20'h00400;

  logic clk, rst, start, out_ready;
  logic busy [2], done [2], en_out [2], eject [2], clear [2];
  logic out_valid [2], out_last [2];
  logic [DW-1:0] data_in [2], out_data [2];
  logic [IW-1:0] out_idx [2];

  // Behavioural PE row models
  logic [DW-1:0] psum [2][N];
  logic [DW-1:0] oreg [2][N];
  logic load_en, acc_en;
  logic [N-1:0][DW-1:0] load_val;

  int vectors = 0;
  int miscompares = 0;

  pe_row_output_drain #(.DW(DW), .N_PE(N), .RELU(0), .CLEAR_PSUM(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
    .pe_en_out(en_out[0]), .pe_eject_ctrl(eject[0]), .pe_clear_psum(clear[0]),
    .data_in(data_in[0]), .out_data(out_data[0]), .out_idx(out_idx[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_last(out_last[0])
  );

  pe_row_output_drain #(.DW(DW), .N_PE(N), .RELU(1), .CLEAR_PSUM(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .done(done[1]),
    .pe_en_out(en_out[1]), .pe_eject_ctrl(eject[1]), .pe_clear_psum(clear[1]),
    .data_in(data_in[1]), .out_data(out_data[1]), .out_idx(out_idx[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_last(out_last[1])
  );

  assign data_in[0] = oreg[0][N-1];
  assign data_in[1] = oreg[1][N-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (en_out[d] && !eject[d]) oreg[d][i] <= psum[d][i];
        else if (en_out[d] && eject[d]) begin
          if (i == 0) oreg[d][i] <= '0;
          else        oreg[d][i] <= oreg[d][i-1];
        end
        if (load_en)       psum[d][i] <= load_val[i];
        else if (clear[d]) psum[d][i] <= '0;
        else if (acc_en)   psum[d][i] <= psum[d][i] + ACC_ONE;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic patbit(input logic [15:0] pat, input int j);
    return (j < 16) ? pat[j] : 1'b1;
  endfunction

  function automatic int done_cycle(input logic [15:0] pat);
    int fires = 0;
    int j = 0;
    while (fires < N) begin
      if (patbit(pat, j)) fires++;
      j++;
    end
    return 3 + j;
  endfunction

  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_busy"},  {31'b0, busy[d]}, 0);
      chk({tag, "_done"},  {31'b0, done[d]}, 0);
      chk({tag, "_valid"}, {31'b0, out_valid[d]}, 0);
      chk({tag, "_en"},    {31'b0, en_out[d]}, 0);
      chk({tag, "_ej"},    {31'b0, eject[d]}, 0);
      chk({tag, "_clr"},   {31'b0, clear[d]}, 0);
      chk({tag, "_data"},  {12'b0, out_data[d]}, 0);
    end
  endtask

  // Runs one drain; cycle 1 is the cycle start is presented.
  task automatic run_drain(input bit do_load, input logic [N-1:0][DW-1:0] ps,
                           input logic [15:0] pat, input logic [N-1:0][DW-1:0] e0,
                           input logic [N-1:0][DW-1:0] e1, input int exp_done,
                           input bit hold_start);
    int c, pos;
    bit seen;
    if (do_load) begin
      @(negedge clk); load_val = ps; load_en = 1'b1;
      @(negedge clk); load_en = 1'b0;
    end
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    c = 1; pos = 0; seen = 0;
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      if (!hold_start) start = 1'b0;
      out_ready = (c >= 3) ? patbit(pat, c - 3) : 1'b0;
      #1;
      if (c == 2) begin
        chk("cap_busy",  {31'b0, busy[0]}, 1);
        chk("cap_en",    {31'b0, en_out[0]}, 1);
        chk("cap_ej",    {31'b0, eject[0]}, 0);
        chk("cap_clr",   {31'b0, clear[0]}, 1);
        chk("cap_valid", {31'b0, out_valid[0]}, 0);
      end else if (pos < N) begin
        chk("drn_valid", {31'b0, out_valid[0]}, 1);
        chk("drn_idx",   {30'b0, out_idx[0]}, N - 1 - pos);
        chk("drn_data",  {12'b0, out_data[0]}, {12'b0, e0[pos]});
        chk("drn_relu",  {12'b0, out_data[1]}, {12'b0, e1[pos]});
        chk("drn_idx1",  {30'b0, out_idx[1]}, N - 1 - pos);
        chk("drn_last",  {31'b0, out_last[0]}, (pos == N - 1) ? 1 : 0);
        chk("drn_en",    {31'b0, en_out[0]}, (out_ready && pos < N - 1) ? 1 : 0);
        chk("drn_ej",    {31'b0, eject[0]}, 1);
        chk("drn_clr",   {31'b0, clear[0]}, 0);
        chk("drn_busy",  {31'b0, busy[0]}, 1);
        if (out_ready) pos++;
      end else begin
        chk("done_pulse", {31'b0, done[0]}, 1);
        chk("done_cycle", c, exp_done);
        chk("done_busy",  {31'b0, busy[0]}, 0);
        chk("done_valid", {31'b0, out_valid[0]}, 0);
        seen = 1;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk); #1;
    chk("post_done", {31'b0, done[0]}, 0);
    chk("post_busy", {31'b0, busy[0]}, 0);
  endtask

  typedef struct {
    logic [N-1:0][DW-1:0] ps;
    logic [15:0]          pat;
    logic [N-1:0][DW-1:0] e0;
    logic [N-1:0][DW-1:0] e1;
    int                   done_c;
  } vec_t;

  vec_t tbl [3];

  initial begin
    logic [N-1:0][DW-1:0] ps, e0, e1, ones;
    logic [15:0] pat;

    tbl[0].ps = {20'h7FFFF, 20'hFFC00, 20'h00C00, 20'h00400};
    tbl[0].pat = 16'hFFFF;
    tbl[0].e0 = {20'h00400, 20'h00C00, 20'hFFC00, 20'h7FFFF};
    tbl[0].e1 = {20'h00400, 20'h00C00, 20'h00000, 20'h7FFFF};
    tbl[0].done_c = 7;
    tbl[1] = tbl[0];
    tbl[1].pat = 16'hFFE9;  // ready 1,0,0,1,0,1,1 then held high
    tbl[1].done_c = 10;
    tbl[2].ps = {20'hFFFFF, 20'h7FFFF, 20'h00001, 20'h80000};
    tbl[2].pat = 16'hFFFF;
    tbl[2].e0 = {20'h80000, 20'h00001, 20'h7FFFF, 20'hFFFFF};
    tbl[2].e1 = {20'h00000, 20'h00001, 20'h7FFFF, 20'h00000};
    tbl[2].done_c = 7;
    ones = {N{ACC_ONE}};

    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    load_en = 1'b0; acc_en = 1'b0; load_val = '0;
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    chk("reset_idx", {30'b0, out_idx[0]}, 0);
    @(negedge clk); rst = 1'b1;

    for (int v = 0; v < 3; v++)
      run_drain(1'b1, tbl[v].ps, tbl[v].pat, tbl[v].e0, tbl[v].e1, tbl[v].done_c, 1'b0);

    // Capture cleared every psum; one accumulate of 1.0*1.0 gives 0x00400 each.
    for (int i = 0; i < N; i++) chk("psum_cleared", {12'b0, psum[0][i]}, 0);
    @(negedge clk); acc_en = 1'b1;
    @(negedge clk); acc_en = 1'b0;
    run_drain(1'b0, '0, 16'hFFFF, ones, ones, 7, 1'b0);

    // Reset during the second DRAIN cycle aborts without a done pulse.
    @(negedge clk); load_val = tbl[0].ps; load_en = 1'b1;
    @(negedge clk); load_en = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;          // CAPTURE
    @(negedge clk); out_ready = 1'b1;      // DRAIN cycle 1
    @(negedge clk); rst = 1'b0;            // DRAIN cycle 2
    @(negedge clk); #1;
    check_quiet("abort");
    rst = 1'b1;
    @(negedge clk); #1;
    check_quiet("abort_idle");
    run_drain(1'b1, tbl[0].ps, 16'hFFFF, tbl[0].e0, tbl[0].e1, 7, 1'b0);

    // start held through DONE: one IDLE cycle, then a new CAPTURE.
    run_drain(1'b1, tbl[0].ps, 16'hFFFF, tbl[0].e0, tbl[0].e1, 7, 1'b1);
    @(negedge clk); #1;
    chk("restart_busy", {31'b0, busy[0]}, 1);
    chk("restart_en",   {31'b0, en_out[0]}, 1);
    chk("restart_ej",   {31'b0, eject[0]}, 0);
    start = 1'b0; out_ready = 1'b1;
    begin
      int budget = 0;
      while (!done[0] && budget < 30) begin
        @(negedge clk); #1;
        budget++;
      end
      chk("restart_done", {31'b0, done[0]}, 1);
      chk("restart_cycles", budget, N + 1);
    end

    // Randomized drains against the reference word order.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) ps[i] = DW'($urandom);
      pat = 16'($urandom);
      for (int k = 0; k < N; k++) begin
        e0[k] = ps[N - 1 - k];
        e1[k] = ps[N - 1 - k][DW-1] ? '0 : ps[N - 1 - k];
      end
      run_drain(1'b1, ps, pat, e0, e1, done_cycle(pat), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
